// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment driver.
// The displayed value is double-buffered, and a new value is only adopted at a frame boundary.
// Each digit slot opens with a ghost-blank gap, and leading zeros can optionally be blanked.
module seg_scan_driver #(
   parameter int unsigned DIV    = 100000,
   parameter int unsigned BLANKW = 1
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic [31:0] value,
   input  logic        load,
   input  logic        blankLead,
   output logic [7:0]  anodes,
   output logic [7:0]  cathnodes,
   output logic        frameDone
);

   localparam int unsigned CW = (DIV > 1)    ? $clog2(DIV)    : 1;
   localparam int unsigned BW = (BLANKW > 1) ? $clog2(BLANKW) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_DRIVE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          tick;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   shown_q, shown_d;
   logic [31:0]   pend_q, pend_d;
   logic          pendv_q, pendv_d;
   logic [7:0]    an_d, cath_d;
   logic          fd_d;
   logic          boundary;
   logic [31:0]   upper;

   // Active-low gfedcba pattern for one hex nibble.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Prescaler: counts 0..DIV-1, wrapping to zero after the last count.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)                      cnt_q <= '0;
      else if (cnt_q == CW'(DIV - 1)) cnt_q <= '0;
      else                            cnt_q <= cnt_q + 1'b1;
   end

   assign tick = (cnt_q == CW'(DIV - 1));

   // Next state, buffer handoff and the registered output values for the state being entered.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      bcnt_d   = bcnt_q;
      shown_d  = shown_q;
      pend_d   = pend_q;
      pendv_d  = pendv_q;
      boundary = 1'b0;
      an_d     = '1;
      cath_d   = '1;
      fd_d     = 1'b0;
      upper    = '0;

      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d  = S_BLANK;
               bcnt_d   = '0;
               boundary = 1'b1;
            end
         end
         S_BLANK: begin
            if (bcnt_q == BW'(BLANKW - 1)) state_d = S_DRIVE;
            else                           bcnt_d  = bcnt_q + 1'b1;
         end
         S_DRIVE: begin
            if (tick) begin
               state_d  = S_BLANK;
               bcnt_d   = '0;
               idx_d    = idx_q + 3'd1;
               boundary = (idx_q == 3'd7);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A load on the boundary edge must not pre-empt the value already pending.
      if (boundary) begin
         fd_d = 1'b1;
         if (pendv_q) begin
            shown_d = pend_q;
            pendv_d = 1'b0;
         end
      end
      if (load) begin
         pend_d  = value;
         pendv_d = 1'b1;
      end

      if (state_d == S_DRIVE) begin
         an_d  = ~(8'h01 << idx_d);
         upper = shown_d >> {idx_d, 2'b00};
         if (!(blankLead && (idx_d != 3'd0) && (upper == '0)))
            cath_d = {1'b1, seg7(upper[3:0])};
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         bcnt_q    <= '0;
         shown_q   <= '0;
         pend_q    <= '0;
         pendv_q   <= 1'b0;
         anodes    <= '1;
         cathnodes <= '1;
         frameDone <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         bcnt_q    <= bcnt_d;
         shown_q   <= shown_d;
         pend_q    <= pend_d;
         pendv_q   <= pendv_d;
         anodes    <= an_d;
         cathnodes <= cath_d;
         frameDone <= fd_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver.
// Expected outputs are derived from the edge count since reset.
// The shown value for frame f is the last value loaded strictly before that frame's boundary edge.
module tb_seg_scan_driver;

   localparam int unsigned DIV    = 4;
   localparam int unsigned BLANKW = 1;
   localparam int unsigned FRAME  = 8 * DIV;
   localparam logic [6:0] SEGTAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [31:0] value = '0;
   logic        load = 1'b0;
   logic        blankLead = 1'b0;
   logic [7:0]  anodes;
   logic [7:0]  cathnodes;
   logic        frameDone;

   int          ncomp = 0;
   int          nfail = 0;
   int unsigned e = 0;
   int unsigned ld_edge [$];
   logic [31:0] ld_val [$];
   logic        bl_edge = 1'b0;

   always #5 clk = ~clk;

   seg_scan_driver #(.DIV(DIV), .BLANKW(BLANKW)) dut (
      .clk(clk), .rstN(rstN), .value(value), .load(load), .blankLead(blankLead),
      .anodes(anodes), .cathnodes(cathnodes), .frameDone(frameDone)
   );

   function automatic logic [31:0] shown_for(input int unsigned f);
      int unsigned b;
      logic [31:0] r;
      b = DIV + FRAME * f;
      r = '0;
      foreach (ld_edge[i]) if (ld_edge[i] < b) r = ld_val[i];
      return r;
   endfunction

   function automatic int unsigned next_boundary(input int unsigned ec);
      if (ec < DIV) return DIV;
      return DIV + FRAME * ((ec - DIV) / FRAME + 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, obs, exp);
      end
   endtask

   // One clock edge, then compare all outputs with the reference.
   task automatic step();
      int unsigned s, p, d, f;
      logic [31:0] sh, up;
      logic [7:0]  ea, ec;
      logic        ef;
      @(posedge clk);
      e++;
      bl_edge = blankLead;
      if (load) begin
         ld_edge.push_back(e);
         ld_val.push_back(value);
      end
      #1;
      ea = 8'hFF; ec = 8'hFF; ef = 1'b0;
      if (e >= DIV) begin
         s  = (e - DIV) / DIV;
         p  = (e - DIV) % DIV;
         d  = s % 8;
         f  = s / 8;
         ef = (p == 0) && (d == 0);
         if (p >= BLANKW) begin
            ea = ~(8'h01 << d);
            sh = shown_for(f);
            up = sh >> (4 * d);
            if (!(bl_edge && d > 0 && up == 0)) ec = {1'b1, SEGTAB[up[3:0]]};
         end
      end
      check("anodes", {24'h0, anodes}, {24'h0, ea});
      check("cathnodes", {24'h0, cathnodes}, {24'h0, ec});
      check("frameDone", {31'h0, frameDone}, {31'h0, ef});
   endtask

   task automatic steps(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [31:0] v);
      value = v;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   task automatic run_to_edge(input int unsigned target);
      while (e + 1 < target) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an"}, {24'h0, anodes}, 32'h0000_00FF);
      check({tag, "_cath"}, {24'h0, cathnodes}, 32'h0000_00FF);
      check({tag, "_fd"}, {31'h0, frameDone}, 32'h0);
   endtask

   initial begin
      // Reset held with clocks running, then release away from the edge.
      rstN = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst_hold");
      @(negedge clk);
      rstN = 1'b1;
      e = 0;

      // 0123ABCD without leading blank, loaded before the first boundary.
      do_load(32'h0123_ABCD);
      steps(2 * FRAME + 4);

      // 00000050 with leading blank, then zero.
      blankLead = 1'b1;
      do_load(32'h0000_0050);
      run_to_edge(next_boundary(e) + 1);
      steps(FRAME);
      do_load(32'h0000_0000);
      run_to_edge(next_boundary(e) + 1);
      steps(FRAME);
      blankLead = 1'b0;

      // Two loads mid-frame: only the latter is ever shown.
      run_to_edge(next_boundary(e) + 5);
      do_load(32'h1111_1111);
      steps(6);
      do_load(32'h2222_2222);
      steps(2 * FRAME);

      // Load on the boundary edge itself with a value already pending.
      run_to_edge(next_boundary(e) + 9);
      do_load(32'hAAAA_5555);
      run_to_edge(next_boundary(e));
      do_load(32'h9876_FEDC);
      steps(2 * FRAME);

      // Random loads and live blankLead changes.
      for (int unsigned i = 0; i < 12 * FRAME; i++) begin
         if ($urandom_range(0, 7) == 0) blankLead = ~blankLead;
         if ($urandom_range(0, 15) == 0) begin
            value = $urandom >> $urandom_range(0, 31);
            load  = 1'b1;
         end
         step();
         load = 1'b0;
      end

      // Reset dropped mid-DRIVE with a value pending.
      do_load(32'h5A5A_5A5A);
      while (((e - DIV) % DIV) < BLANKW) step();
      #1 rstN = 1'b0;
      #1 check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("rst_mid_hold");
      ld_edge.delete();
      ld_val.delete();
      @(negedge clk);
      rstN = 1'b1;
      e = 0;
      steps(FRAME + DIV + 2);

      // Random loads after the reset.
      for (int unsigned i = 0; i < 3 * FRAME; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            value = $urandom;
            load  = 1'b1;
         end
         blankLead = ($urandom_range(0, 3) == 0);
         step();
         load = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
